hyperbus_cfg_seq: RTL



---
 rtl/hyperbus_cfg_seq_if.sv | 26 ++
 rtl/hyperbus_cfg_seq.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/hyperbus_cfg_seq_if.sv
// Register bus between the config sequencer (master) and the HyperBus config register file (slave).
// The request holds addr/write/wdata/wstrb/valid; the response holds rdata/error/ready.
interface hyperbus_cfg_seq_if #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32
);
    typedef struct packed {
        logic [AddrWidth-1:0]   addr;
        logic                   write;
        logic [DataWidth-1:0]   wdata;
        logic [DataWidth/8-1:0] wstrb;
        logic                   valid;
    } reg_req_t;

    typedef struct packed {
        logic [DataWidth-1:0] rdata;
        logic                 error;
        logic                 ready;
    } reg_rsp_t;

    reg_req_t reg_req;
    reg_rsp_t reg_rsp;

    modport master (output reg_req, input reg_rsp);
    modport slave  (input reg_req, output reg_rsp);
endinterface

// File: rtl/hyperbus_cfg_seq.sv
// Writes a parameter table to the HyperBus config registers, then optionally reads it back under a mask.
// One entry per cycle while ready stays high; the request is held while ready is low, and the sequence aborts after TimeoutCycles stalled cycles.
module hyperbus_cfg_seq #(
    parameter int unsigned NumEntries    = 4,
    parameter int unsigned RegAddrWidth  = 32,
    parameter int unsigned RegDataWidth  = 32,
    parameter logic [NumEntries-1:0][RegAddrWidth-1:0] EntryAddr = '0,
    parameter logic [NumEntries-1:0][RegDataWidth-1:0] EntryData = '0,
    parameter logic [NumEntries-1:0][RegDataWidth-1:0] EntryMask = '1,
    parameter bit          Verify        = 1'b1,
    parameter bit          AutoStart     = 1'b1,
    parameter int unsigned TimeoutCycles = 1024,
    localparam int unsigned IdxWidth = (NumEntries > 1) ? $clog2(NumEntries) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    hyperbus_cfg_seq_if.master  reg_bus,
    output logic                busy_o,
    output logic                done_o,
    output logic                error_o,
    output logic [1:0]          err_code_o,
    output logic [IdxWidth-1:0] err_idx_o
);
    typedef struct packed {
        logic [RegAddrWidth-1:0]   addr;
        logic                      write;
        logic [RegDataWidth-1:0]   wdata;
        logic [RegDataWidth/8-1:0] wstrb;
        logic                      valid;
    } req_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } state_t;

    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumEntries - 1);
    localparam logic [31:0]         TmoLast = 32'(TimeoutCycles - 1);

    state_t              state_q;
    req_t                req_q;
    logic [IdxWidth-1:0] idx_q;
    logic [31:0]         tmo_q;
    logic                auto_pend_q;

    logic hs;
    logic mismatch;

    assign reg_bus.reg_req = req_q;
    assign hs       = req_q.valid & reg_bus.reg_rsp.ready;
    assign mismatch = |((reg_bus.reg_rsp.rdata ^ EntryData[idx_q]) & EntryMask[idx_q]);

    // Reads carry no data or strobes; only writes drive wdata/wstrb.
    function automatic req_t make_req(input logic wr, input logic [IdxWidth-1:0] idx);
        req_t r;
        r       = '0;
        r.valid = 1'b1;
        r.write = wr;
        r.addr  = EntryAddr[idx];
        if (wr) begin
            r.wdata = EntryData[idx];
            r.wstrb = '1;
        end
        return r;
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            req_q       <= '0;
            idx_q       <= '0;
            tmo_q       <= '0;
            auto_pend_q <= AutoStart;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            error_o     <= 1'b0;
            err_code_o  <= 2'd0;
            err_idx_o   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (auto_pend_q || start_i) begin
                        auto_pend_q <= 1'b0;
                        state_q     <= WRITE;
                        idx_q       <= '0;
                        tmo_q       <= '0;
                        req_q       <= make_req(1'b1, '0);
                        busy_o      <= 1'b1;
                    end
                end

                WRITE, READ: begin
                    if (hs) begin
                        tmo_q <= '0;
                        if (reg_bus.reg_rsp.error) begin
                            state_q    <= ERROR;
                            req_q      <= '0;
                            busy_o     <= 1'b0;
                            error_o    <= 1'b1;
                            err_code_o <= 2'd1;
                            err_idx_o  <= idx_q;
                        end else if (state_q == READ && mismatch) begin
                            state_q    <= ERROR;
                            req_q      <= '0;
                            busy_o     <= 1'b0;
                            error_o    <= 1'b1;
                            err_code_o <= 2'd2;
                            err_idx_o  <= idx_q;
                        end else if (idx_q != LastIdx) begin
                            idx_q <= idx_q + 1'b1;
                            req_q <= make_req(state_q == WRITE, idx_q + 1'b1);
                        end else if (state_q == WRITE && Verify) begin
                            state_q <= READ;
                            idx_q   <= '0;
                            req_q   <= make_req(1'b0, '0);
                        end else begin
                            state_q <= DONE;
                            req_q   <= '0;
                            busy_o  <= 1'b0;
                            done_o  <= 1'b1;
                        end
                    end else if (TimeoutCycles != 0) begin
                        // valid is always high here, so every non-handshake cycle is a stall.
                        if (tmo_q == TmoLast) begin
                            state_q    <= ERROR;
                            req_q      <= '0;
                            tmo_q      <= '0;
                            busy_o     <= 1'b0;
                            error_o    <= 1'b1;
                            err_code_o <= 2'd3;
                            err_idx_o  <= idx_q;
                        end else begin
                            tmo_q <= tmo_q + 1'b1;
                        end
                    end
                end

                DONE, ERROR: begin
                    if (start_i) begin
                        state_q    <= WRITE;
                        idx_q      <= '0;
                        tmo_q      <= '0;
                        req_q      <= make_req(1'b1, '0);
                        busy_o     <= 1'b1;
                        done_o     <= 1'b0;
                        error_o    <= 1'b0;
                        err_code_o <= 2'd0;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    req_q   <= '0;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end
endmodule
